// File: rtl/jtag_buffer_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : jtag_buffer_ctrl_if
// Purpose  : Host-side (FT2232) signal bundle for the JTAG buffer controller.
// Revision : 1.0 - initial release
// ============================================================================
interface jtag_buffer_ctrl_if #(
  parameter int N_OUT = 5
);
  logic             ft_jtag_oe;
  logic [N_OUT-1:0] ft_out;
  logic             ft_nsrst_oe;
  logic             ft_nsrst_out;
  logic             ft_nsrst_in;
  logic             ft_ntrst_oe;
  logic             ft_ntrst_out;
  logic             ft_tdo;
  logic             ft_dbgack;
  logic             ft_target_present;

  modport master (
    output ft_jtag_oe, ft_out, ft_nsrst_oe, ft_nsrst_out, ft_ntrst_oe, ft_ntrst_out,
    input  ft_nsrst_in, ft_tdo, ft_dbgack, ft_target_present
  );

  modport slave (
    input  ft_jtag_oe, ft_out, ft_nsrst_oe, ft_nsrst_out, ft_ntrst_oe, ft_ntrst_out,
    output ft_nsrst_in, ft_tdo, ft_dbgack, ft_target_present
  );
endinterface
`default_nettype wire

// File: rtl/jtag_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : jtag_buffer_ctrl
// Purpose  : Clocked JTAG line buffer with presence debounce, attach/drive FSM
//            and nSRST/nTRST minimum-width stretchers. Optional LOOPBACK_EN
//            macro adds a host TDI->TDO self-test loopback.
// Revision : 1.0 - initial release
// ============================================================================
module jtag_buffer_ctrl #(
  parameter int N_OUT       = 5,
  parameter int DEB_CYC     = 200,
  parameter int STRETCH_CYC = 100
) (
  input  wire              clk,
  input  wire              rst,
  jtag_buffer_ctrl_if.slave host,
`ifdef LOOPBACK_EN
  input  wire              loopback,
`endif
  output wire [N_OUT-1:0]  tgt_out,
  inout  wire              nsrst,
  inout  wire              ntrst,
  input  wire              tdo,
  input  wire              dbgack,
  input  wire              target_present,
  output wire [1:0]        state
);

  localparam int DW = $clog2(DEB_CYC);
  localparam int SW = $clog2(STRETCH_CYC + 1);

  typedef enum logic [1:0] {
    DETACHED = 2'd0,
    ATTACHED = 2'd1,
    DRIVING  = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic            r_drive_en;
  logic            r_pres_s1, r_pres_s2;
  logic            r_oe_s1, r_oe_s2;
  logic            r_nsrst_s1, r_nsrst_s2;
  logic            r_deb;
  logic [DW-1:0]   r_deb_cnt;
  logic [1:0]      w_rst_oe;
  logic [1:0]      w_rst_out;
  logic [1:0]      w_pin_low;
  logic [1:0]      w_pin_high;

  // Sync flops idle high: deasserted oe, no pin activity, present assumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pres_s1  <= 1'b1;
      r_pres_s2  <= 1'b1;
      r_oe_s1    <= 1'b1;
      r_oe_s2    <= 1'b1;
      r_nsrst_s1 <= 1'b1;
      r_nsrst_s2 <= 1'b1;
    end else begin
      r_pres_s1  <= target_present;
      r_pres_s2  <= r_pres_s1;
      r_oe_s1    <= host.ft_jtag_oe;
      r_oe_s2    <= r_oe_s1;
      r_nsrst_s1 <= nsrst;
      r_nsrst_s2 <= r_nsrst_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_deb     <= 1'b0;
      r_deb_cnt <= '0;
    end else if (r_pres_s2 == r_deb) begin
      r_deb_cnt <= '0;
    end else if (r_deb_cnt == DW'(DEB_CYC - 1)) begin
      r_deb     <= ~r_deb;
      r_deb_cnt <= '0;
    end else begin
      r_deb_cnt <= r_deb_cnt + DW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= DETACHED;
      r_drive_en <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_drive_en <= (w_next == DRIVING);
    end
  end

  // Loss of target outranks any oe request.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DETACHED: if (r_deb) w_next = ATTACHED;
      ATTACHED: begin
        if (!r_deb)        w_next = DETACHED;
        else if (!r_oe_s2) w_next = DRIVING;
      end
      DRIVING: begin
        if (!r_deb)        w_next = DETACHED;
        else if (r_oe_s2)  w_next = ATTACHED;
      end
      default:             w_next = DETACHED;
    endcase
  end

  assign w_rst_oe  = {host.ft_ntrst_oe,  host.ft_nsrst_oe};
  assign w_rst_out = {host.ft_ntrst_out, host.ft_nsrst_out};

  for (genvar g = 0; g < 2; g++) begin : g_stretch
    logic          w_req;
    logic          r_req_d;
    logic [SW-1:0] r_cnt;

    assign w_req = ~w_rst_oe[g] & ~w_rst_out[g];

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        r_req_d <= 1'b0;
        r_cnt   <= '0;
      end else begin
        r_req_d <= w_req;
        if (w_next == DETACHED)
          r_cnt <= '0;
        else if (w_req && !r_req_d)
          r_cnt <= SW'(STRETCH_CYC);
        else if (r_cnt != '0)
          r_cnt <= r_cnt - SW'(1);
      end
    end

    assign w_pin_low[g]  = (r_state != DETACHED) && (w_req || (r_cnt != '0));
    assign w_pin_high[g] = (r_state != DETACHED) && !w_pin_low[g] &&
                           !w_rst_oe[g] && w_rst_out[g];
  end

  assign nsrst = w_pin_low[0] ? 1'b0 : (w_pin_high[0] ? 1'b1 : 1'bz);
  assign ntrst = w_pin_low[1] ? 1'b0 : (w_pin_high[1] ? 1'b1 : 1'bz);

  assign tgt_out = r_drive_en ? host.ft_out : {N_OUT{1'bz}};

`ifdef LOOPBACK_EN
  assign host.ft_tdo = (loopback && (r_state != DRIVING)) ? host.ft_out[0] : tdo;
`else
  assign host.ft_tdo = tdo;
`endif

  assign host.ft_dbgack         = dbgack;
  assign host.ft_nsrst_in       = r_nsrst_s2;
  assign host.ft_target_present = r_deb;
  assign state                  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_jtag_buffer_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtag_buffer_ctrl
// Purpose  : Self-checking bench for jtag_buffer_ctrl (DEB_CYC=4, STRETCH_CYC=3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_jtag_buffer_ctrl;
  localparam int N_OUT = 5;
  localparam int DEB   = 4;
  localparam int STR   = 3;

  logic clk = 1'b0;
  logic rst;
  logic tdo, dbgack, target_present;
`ifdef LOOPBACK_EN
  logic loopback;
`endif
  wire [N_OUT-1:0] tgt_out;
  wire             nsrst, ntrst;
  wire [1:0]       state;

  always #5 clk = ~clk;

  jtag_buffer_ctrl_if #(.N_OUT(N_OUT)) host ();

  // Board pull-ups: an undriven line reads back as 1.
  for (genvar i = 0; i < N_OUT; i++) begin : g_pu
    pullup (tgt_out[i]);
  end
  pullup (nsrst);
  pullup (ntrst);

  jtag_buffer_ctrl #(.N_OUT(N_OUT), .DEB_CYC(DEB), .STRETCH_CYC(STR)) dut (
    .clk            (clk),
    .rst            (rst),
    .host           (host),
`ifdef LOOPBACK_EN
    .loopback       (loopback),
`endif
    .tgt_out        (tgt_out),
    .nsrst          (nsrst),
    .ntrst          (ntrst),
    .tdo            (tdo),
    .dbgack         (dbgack),
    .target_present (target_present),
    .state          (state)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycle-stamped, queue-based view of the behaviour.
  int  n;
  bit  m_deb;
  int  m_run;
  int  m_mode;
  bit  pq[$], oq[$], nq[$];
  int  low_until[2];
  bit  prev_req[2];

  function automatic void m_reset();
    n = 0; m_deb = 0; m_run = 0; m_mode = 0;
    pq = '{1'b1, 1'b1}; oq = '{1'b1, 1'b1}; nq = '{1'b1, 1'b1};
    low_until = '{0, 0}; prev_req = '{1'b0, 1'b0};
  endfunction

  function automatic bit req(input int ch);
    if (ch == 0) return !host.ft_nsrst_oe && !host.ft_nsrst_out;
    return !host.ft_ntrst_oe && !host.ft_ntrst_out;
  endfunction

  function automatic bit exp_pin(input int ch);
    if (m_mode == 0) return 1'b1;
    if (req(ch) || (n < low_until[ch])) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit exp_tdo();
`ifdef LOOPBACK_EN
    if (loopback && m_mode != 2) return host.ft_out[0];
`endif
    return tdo;
  endfunction

  task automatic check_all();
    logic [N_OUT-1:0] et;
    et = (m_mode == 2) ? host.ft_out : '1;
    chk("tgt_out", 32'(tgt_out), 32'(et));
    chk("state", 32'(state), 32'(m_mode));
    chk("ft_target_present", 32'(host.ft_target_present), 32'(m_deb));
    chk("ft_nsrst_in", 32'(host.ft_nsrst_in), 32'(nq[0]));
    chk("nsrst", 32'(nsrst), 32'(exp_pin(0)));
    chk("ntrst", 32'(ntrst), 32'(exp_pin(1)));
    chk("ft_tdo", 32'(host.ft_tdo), 32'(exp_tdo()));
    chk("ft_dbgack", 32'(host.ft_dbgack), 32'(dbgack));
  endtask

  task automatic model_edge();
    bit s_pres, s_oe, pin0;
    int nxt, n_new;
    s_pres = pq[0];
    s_oe   = oq[0];
    pin0   = exp_pin(0);
    n_new  = n + 1;
    case (m_mode)
      0:       nxt = m_deb ? 1 : 0;
      1:       nxt = !m_deb ? 0 : (!s_oe ? 2 : 1);
      default: nxt = !m_deb ? 0 : (s_oe ? 1 : 2);
    endcase
    if (s_pres == m_deb) m_run = 0;
    else begin
      m_run++;
      if (m_run == DEB) begin m_deb = !m_deb; m_run = 0; end
    end
    for (int ch = 0; ch < 2; ch++) begin
      bit r;
      r = req(ch);
      if (nxt == 0) low_until[ch] = 0;
      else if (r && !prev_req[ch]) low_until[ch] = n_new + STR;
      prev_req[ch] = r;
    end
    void'(pq.pop_front()); pq.push_back(target_present);
    void'(oq.pop_front()); oq.push_back(host.ft_jtag_oe);
    void'(nq.pop_front()); nq.push_back(pin0);
    m_mode = nxt;
    n = n_new;
  endtask

  task automatic tick();
    #2;
    check_all();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [N_OUT-1:0] fo;
    logic             td;
    logic             da;
    logic [N_OUT-1:0] exp_tgt;
    logic             exp_tdo;
    logic             exp_da;
  } vec_t;

  vec_t vecs[4];
  logic [2:0] s4_out [8];
  logic [2:0] s4_exp [8];
  int cnt;

  initial begin
    vecs[0] = '{5'b10101, 1'b1, 1'b0, 5'b10101, 1'b1, 1'b0};
    vecs[1] = '{5'b01010, 1'b0, 1'b1, 5'b01010, 1'b0, 1'b1};
    vecs[2] = '{5'b00000, 1'b1, 1'b1, 5'b00000, 1'b1, 1'b1};
    vecs[3] = '{5'b11001, 1'b0, 1'b0, 5'b11001, 1'b0, 1'b0};
    s4_out = '{3'd0, 3'd1, 3'd1, 3'd0, 3'd1, 3'd1, 3'd1, 3'd1};
    s4_exp = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0, 3'd1};

    rst = 1'b1;
    host.ft_jtag_oe = 1'b1; host.ft_out = 5'b10101;
    host.ft_nsrst_oe = 1'b1; host.ft_nsrst_out = 1'b1;
    host.ft_ntrst_oe = 1'b1; host.ft_ntrst_out = 1'b1;
    tdo = 1'b0; dbgack = 1'b0; target_present = 1'b0;
`ifdef LOOPBACK_EN
    loopback = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_reset();

    // Reset state
    #1;
    chk("rst tgt_out", 32'(tgt_out), 32'h1f);
    chk("rst nsrst", 32'(nsrst), 32'd1);
    chk("rst present", 32'(host.ft_target_present), 32'd0);
    chk("rst state", 32'(state), 32'd0);
    chk("rst nsrst_in", 32'(host.ft_nsrst_in), 32'd1);
    #1;   // back to edge+1 alignment minus tick's own delay
    tick(); tick(); tick();

`ifdef LOOPBACK_EN
    loopback = 1'b1; tdo = 1'b1;
    for (int k = 0; k < 4; k++) begin
      host.ft_out[0] = k[0];
      #1;
      chk("loopback tdo", 32'(host.ft_tdo), 32'(k[0]));
    end
    tick();
    loopback = 1'b0; tdo = 1'b0; host.ft_out = 5'b10101;
`endif

    // Presence with a 2-cycle glitch
    for (int k = 0; k < 9; k++) begin
      target_present = (k == 2 || k == 3) ? 1'b0 : 1'b1;
      tick();
    end
    chk("deb no early flip", 32'(host.ft_target_present), 32'd0);
    tick();
    chk("deb flipped", 32'(host.ft_target_present), 32'd1);
    tick();
    chk("attached", 32'(state), 32'd1);

    // Drive and release latency
    host.ft_jtag_oe = 1'b0;
    tick(); tick();
    chk("drive edge2", 32'(tgt_out), 32'h1f);
    tick();
    chk("drive edge3", 32'(tgt_out), 32'h15);
    chk("driving", 32'(state), 32'd2);
    host.ft_jtag_oe = 1'b1;
    tick(); tick();
    chk("release edge2", 32'(tgt_out), 32'h15);
    tick();
    chk("release edge3", 32'(tgt_out), 32'h1f);
    host.ft_jtag_oe = 1'b0;
    tick(); tick(); tick();

    // Zero-latency data path while driving
    for (int k = 0; k < 4; k++) begin
      host.ft_out = vecs[k].fo; tdo = vecs[k].td; dbgack = vecs[k].da;
      #1;
      chk("vec tgt_out", 32'(tgt_out), 32'(vecs[k].exp_tgt));
      chk("vec ft_tdo", 32'(host.ft_tdo), 32'(vecs[k].exp_tdo));
      chk("vec ft_dbgack", 32'(host.ft_dbgack), 32'(vecs[k].exp_da));
      #(-1 + 1);
      tick();
    end

    // nSRST stretch with re-assert at count 1
    host.ft_nsrst_oe = 1'b0;
    for (int k = 0; k < 8; k++) begin
      host.ft_nsrst_out = s4_out[k][0];
      #1;
      chk("nsrst stretch", 32'(nsrst), 32'(s4_exp[k][0]));
      tick();
    end
    host.ft_nsrst_oe = 1'b1; host.ft_nsrst_out = 1'b1;
    tick(); tick();

    // Target loss during an nTRST stretch
    host.ft_ntrst_oe = 1'b0; host.ft_ntrst_out = 1'b1;
    for (int k = 0; k < 8; k++) begin
      target_present = 1'b0;
      host.ft_ntrst_out = (k == 5) ? 1'b0 : 1'b1;
      if (k == 6) begin
        #1;
        chk("ntrst stretching", 32'(ntrst), 32'd0);
        chk("still driving", 32'(state), 32'd2);
      end
      tick();
    end
    chk("lost state", 32'(state), 32'd0);
    chk("lost tgt_out", 32'(tgt_out), 32'h1f);
    chk("lost ntrst", 32'(ntrst), 32'd1);

    // Re-attach and async reset mid-drive
    target_present = 1'b1;
    cnt = 0;
    while (state != 2'd2 && cnt < 30) begin tick(); cnt++; end
    chk("reattach in budget", 32'(cnt < 30), 32'd1);
    host.ft_nsrst_oe = 1'b0; host.ft_nsrst_out = 1'b0;
    rst = 1'b1;
    #1;
    chk("async rst tgt_out", 32'(tgt_out), 32'h1f);
    chk("async rst state", 32'(state), 32'd0);
    chk("async rst present", 32'(host.ft_target_present), 32'd0);
    chk("async rst nsrst", 32'(nsrst), 32'd1);
    chk("async rst nsrst_in", 32'(host.ft_nsrst_in), 32'd1);
    rst = 1'b0;
    m_reset();
    tick();

    // Randomised phase against the model
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 29) == 0) target_present = !target_present;
      if ($urandom_range(0, 7) == 0)  host.ft_jtag_oe = !host.ft_jtag_oe;
      host.ft_out       = N_OUT'($urandom);
      tdo               = 1'($urandom);
      dbgack            = 1'($urandom);
      host.ft_nsrst_oe  = ($urandom_range(0, 3) == 0);
      host.ft_nsrst_out = ($urandom_range(0, 4) != 0);
      host.ft_ntrst_oe  = ($urandom_range(0, 3) == 0);
      host.ft_ntrst_out = ($urandom_range(0, 4) != 0);
`ifdef LOOPBACK_EN
      loopback = 1'($urandom);
`endif
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
